// File: rtl/alu_bist_pkg.sv
// Shared definitions for the ALU built-in self-test: MISR polynomial,
// default seed and the controller state encoding.
package alu_bist_pkg;

  // x^16 + x^12 + x^3 + x + 1
  localparam logic [15:0] POLY         = 16'h100B;
  localparam logic [15:0] DEFAULT_SEED = 16'hFFFF;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

endpackage

// File: rtl/alu_bist_misr.sv
// Multiple-input signature register that compresses one ALU response per
// enabled cycle; load restarts it from the seed.
module alu_bist_misr
  import alu_bist_pkg::*;
#(
  parameter int               SIG_W = 16,
  parameter logic [SIG_W-1:0] SEED  = SIG_W'(DEFAULT_SEED)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             enable,
  input  logic [SIG_W-1:0] data_in,
  output logic [SIG_W-1:0] sig_out
);

  localparam logic [SIG_W-1:0] POLY_W = SIG_W'(POLY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_out <= SEED;
    end else if (load) begin
      sig_out <= SEED;
    end else if (enable) begin
      sig_out <= {sig_out[SIG_W-2:0], 1'b0} ^ (sig_out[SIG_W-1] ? POLY_W : '0) ^ data_in;
    end
  end

endmodule

// File: rtl/alu_bist.sv
// ALU self-test controller: sweeps every op/carry/operand combination once,
// folds the ALU responses into a MISR and compares the result to a golden value.
module alu_bist
  import alu_bist_pkg::*;
#(
  parameter int               WIDTH = 4,
  parameter int               SIG_W = 16,
  parameter logic [SIG_W-1:0] SEED  = SIG_W'(DEFAULT_SEED)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [SIG_W-1:0] expected_sig,
  output logic [2:0]       alu_op,
  output logic             alu_in_c,
  output logic [WIDTH-1:0] alu_in_x,
  output logic [WIDTH-1:0] alu_in_y,
  input  logic [WIDTH-1:0] alu_out_s,
  input  logic             alu_out_c,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] signature
);

  localparam int               N      = 4 + 2 * WIDTH;
  localparam logic [N-1:0]     CNT_ONE = {{(N - 1){1'b0}}, 1'b1};
  localparam logic [SIG_W-1:0] POLY_W = SIG_W'(POLY);

  state_t           state, state_next;
  logic [N-1:0]     cnt;
  logic             run_start;
  logic             last_vec;
  logic [WIDTH+2:0] resp;
  logic [SIG_W-1:0] resp_ext;
  logic [SIG_W-1:0] misr_next;

  assign last_vec = (cnt == '1);
  assign resp     = {alu_zero, alu_overflow, alu_out_c, alu_out_s};
  assign resp_ext = SIG_W'(resp);

  // Value the MISR takes at this edge; needed to judge pass on the final vector.
  assign misr_next = {signature[SIG_W-2:0], 1'b0} ^ (signature[SIG_W-1] ? POLY_W : '0) ^ resp_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    run_start  = 1'b0;
    busy       = 1'b0;
    alu_op     = '0;
    alu_in_c   = 1'b0;
    alu_in_x   = '0;
    alu_in_y   = '0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          run_start  = 1'b1;
        end
      end
      RUN: begin
        busy     = 1'b1;
        alu_op   = cnt[N-1:N-3];
        alu_in_c = cnt[2*WIDTH];
        alu_in_x = cnt[2*WIDTH-1:WIDTH];
        alu_in_y = cnt[WIDTH-1:0];
        if (last_vec) begin
          state_next = IDLE;
        end
      end
    endcase
  end

  // Counter wraps to zero on the last vector, leaving it ready for the next run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      done <= 1'b0;
      pass <= 1'b0;
    end else begin
      done <= 1'b0;
      if (run_start) begin
        cnt  <= '0;
        pass <= 1'b0;
      end else if (state == RUN) begin
        cnt <= cnt + CNT_ONE;
        if (last_vec) begin
          done <= 1'b1;
          pass <= (misr_next == expected_sig);
        end
      end
    end
  end

  alu_bist_misr #(
    .SIG_W (SIG_W),
    .SEED  (SEED)
  ) u_misr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (run_start),
    .enable  (state == RUN),
    .data_in (resp_ext),
    .sig_out (signature)
  );

endmodule

// File: tb/tb_alu_bist.sv
// Directed self-checking bench for alu_bist, driving a behavioural 4-bit ALU
// (optionally with out_s[0] stuck at 1) and a reference signature model.
module tb_alu_bist;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] expected_sig = 16'h0;
  logic [2:0]  alu_op;
  logic        alu_in_c;
  logic [3:0]  alu_in_x;
  logic [3:0]  alu_in_y;
  logic [3:0]  alu_out_s;
  logic        alu_out_c;
  logic        alu_zero;
  logic        alu_overflow;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] signature;

  logic        fault = 1'b0;
  logic [6:0]  alu_resp;
  logic [15:0] golden;
  logic [15:0] golden_faulty;
  int          checks = 0;
  int          failures = 0;
  int          busy_cycles;
  int          done_count;
  bit          saw_done;

  always #5 clk = ~clk;

  alu_bist #(
    .WIDTH (4),
    .SIG_W (16),
    .SEED  (16'hFFFF)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .expected_sig (expected_sig),
    .alu_op       (alu_op),
    .alu_in_c     (alu_in_c),
    .alu_in_x     (alu_in_x),
    .alu_in_y     (alu_in_y),
    .alu_out_s    (alu_out_s),
    .alu_out_c    (alu_out_c),
    .alu_zero     (alu_zero),
    .alu_overflow (alu_overflow),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .signature    (signature)
  );

  // Returns {zero, overflow, carry_out, sum}
  function automatic logic [6:0] alu_ref(input logic [2:0] op, input logic c,
                                         input logic [3:0] x, input logic [3:0] y);
    logic [4:0] sum;
    logic [3:0] s;
    logic       co;
    logic       ov;
    sum = '0;
    s   = '0;
    co  = 1'b0;
    ov  = 1'b0;
    case (op)
      3'd0: begin
        sum = {1'b0, x} + {1'b0, y} + {4'b0, c};
        s   = sum[3:0];
        co  = sum[4];
        ov  = (x[3] == y[3]) && (s[3] != x[3]);
      end
      3'd1: begin
        sum = {1'b0, x} + {1'b0, ~y} + {4'b0, c};
        s   = sum[3:0];
        co  = sum[4];
        ov  = (x[3] != y[3]) && (s[3] != x[3]);
      end
      3'd2: s = x & y;
      3'd3: s = x | y;
      3'd4: s = x ^ y;
      3'd5: s = ~x;
      3'd6: begin
        s  = {x[2:0], c};
        co = x[3];
      end
      default: s = y;
    endcase
    return {(s == 4'd0), ov, co, s};
  endfunction

  function automatic logic [15:0] modelSignature(input bit stuck);
    logic [15:0] m;
    logic [11:0] v;
    logic [6:0]  r;
    m = 16'hFFFF;
    for (int i = 0; i < 4096; i++) begin
      v = 12'(i);
      r = alu_ref(v[11:9], v[8], v[7:4], v[3:0]);
      if (stuck) r[0] = 1'b1;
      m = {m[14:0], 1'b0} ^ (m[15] ? 16'h100B : 16'h0000) ^ {9'b0, r};
    end
    return m;
  endfunction

  always_comb begin
    alu_resp     = alu_ref(alu_op, alu_in_c, alu_in_x, alu_in_y);
    alu_out_s    = alu_resp[3:0] | {3'b000, fault};
    alu_out_c    = alu_resp[4];
    alu_overflow = alu_resp[5];
    alu_zero     = alu_resp[6];
  end

  task automatic applyStimulus(input logic s, input logic r, input logic [15:0] e);
    start        = s;
    rst_n        = r;
    expected_sig = e;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Called on the first negedge of a run; returns on the negedge showing done.
  task automatic runToDone(output int cycles, output bit seen);
    cycles = 0;
    seen   = 1'b0;
    for (int i = 0; i < 5000 && !seen; i++) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        if (busy) cycles++;
        @(negedge clk);
      end
    end
  endtask

  task automatic startRun(input logic [15:0] e);
    applyStimulus(1'b1, 1'b1, e);
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, e);
  endtask

  initial begin
    golden        = modelSignature(1'b0);
    golden_faulty = modelSignature(1'b1);

    // Reset state
    applyStimulus(1'b0, 1'b0, 16'h0);
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_pass", pass, 0);
    checkOutput("rst_sig", signature, 16'hFFFF);
    checkOutput("rst_vec", {alu_op, alu_in_c, alu_in_x, alu_in_y}, 0);
    applyStimulus(1'b0, 1'b1, golden);
    repeat (2) @(negedge clk);
    checkOutput("idle_busy", busy, 0);

    // Run 1: golden expected, extra start at vector 50, directed vector probes
    startRun(golden);
    checkOutput("start_busy", busy, 1);
    checkOutput("first_vec", {alu_op, alu_in_c, alu_in_x, alu_in_y}, 0);
    busy_cycles = 0;
    saw_done    = 1'b0;
    for (int i = 0; i < 5000 && !saw_done; i++) begin
      if (done) begin
        saw_done = 1'b1;
      end else begin
        if (i == 1) checkOutput("sig_after_vec0", signature, 16'hEFB5);
        if (i == 50) start = 1'b1;
        if (i == 51) start = 1'b0;
        if (i == 52) checkOutput("vec_52", {alu_op, alu_in_c, alu_in_x, alu_in_y}, 12'h034);
        if (i == 12'h123) begin
          checkOutput("vec123_op", alu_op, 0);
          checkOutput("vec123_c", alu_in_c, 1);
          checkOutput("vec123_x", alu_in_x, 2);
          checkOutput("vec123_y", alu_in_y, 3);
        end
        if (busy) busy_cycles++;
        @(negedge clk);
      end
    end
    checkOutput("run1_done_seen", saw_done, 1);
    checkOutput("run1_busy_cycles", busy_cycles, 4096);
    checkOutput("run1_busy_cleared", busy, 0);
    checkOutput("run1_pass", pass, 1);
    checkOutput("run1_sig", signature, golden);
    @(negedge clk);
    checkOutput("run1_done_pulse", done, 0);
    checkOutput("run1_pass_held", pass, 1);
    checkOutput("run1_idle_vec", {alu_op, alu_in_c, alu_in_x, alu_in_y}, 0);
    checkOutput("run1_sig_frozen", signature, golden);

    // Run 2: expected signature with bit 0 flipped
    startRun(golden ^ 16'h0001);
    checkOutput("run2_pass_cleared", pass, 0);
    runToDone(busy_cycles, saw_done);
    checkOutput("run2_done_seen", saw_done, 1);
    checkOutput("run2_busy_cycles", busy_cycles, 4096);
    checkOutput("run2_pass", pass, 0);
    checkOutput("run2_sig", signature, golden);
    @(negedge clk);

    // Run 3: ALU with out_s[0] stuck at 1
    fault = 1'b1;
    startRun(golden);
    runToDone(busy_cycles, saw_done);
    checkOutput("run3_done_seen", saw_done, 1);
    checkOutput("run3_pass", pass, 0);
    checkOutput("run3_sig_differs", (signature != golden), 1);
    checkOutput("run3_sig_model", signature, golden_faulty);
    fault = 1'b0;
    @(negedge clk);

    // Run 4: reset asserted at vector 100
    startRun(golden);
    repeat (100) @(negedge clk);
    checkOutput("run4_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_vec", {alu_op, alu_in_c, alu_in_x, alu_in_y}, 0);
    checkOutput("abort_sig", signature, 16'hFFFF);
    checkOutput("abort_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    done_count  = 0;
    busy_cycles = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) done_count++;
      if (busy) busy_cycles++;
    end
    checkOutput("abort_no_done", done_count, 0);
    checkOutput("abort_no_resume", busy_cycles, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_bist.md
ALU_BIST -- requirements
Module: alu_bist

Interface
REQ-001 SHALL have parameter WIDTH, default 4, the ALU operand width.
REQ-002 SHALL have parameter SIG_W, default 16, the signature width; WIDTH+3 <= SIG_W.
REQ-003 SHALL have parameter SEED, default 16'hFFFF, the MISR start value.
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  input  1  begin a test run, sampled in IDLE only.
REQ-007 SHALL have port expected_sig  input  SIG_W  golden signature, sampled at end of run.
REQ-008 SHALL have port alu_op  output  3  ALU operation select.
REQ-009 SHALL have port alu_in_c  output  1  ALU carry-in.
REQ-010 SHALL have port alu_in_x  output  WIDTH  ALU operand x.
REQ-011 SHALL have port alu_in_y  output  WIDTH  ALU operand y.
REQ-012 SHALL have port alu_out_s  input  WIDTH  ALU result.
REQ-013 SHALL have port alu_out_c  input  1  ALU carry-out.
REQ-014 SHALL have port alu_zero  input  1  ALU zero flag.
REQ-015 SHALL have port alu_overflow  input  1  ALU overflow flag.
REQ-016 SHALL have port busy  output  1  run in progress.
REQ-017 SHALL have port done  output  1  one-cycle pulse at end of run.
REQ-018 SHALL have port pass  output  1  final signature equals expected_sig; held until next start.
REQ-019 SHALL have port signature  output  SIG_W  current MISR value.

Function
REQ-020 SHALL implement FSM states IDLE and RUN; IDLE->RUN on start=1, RUN->IDLE after the last vector.
REQ-021 SHALL hold an N-bit vector counter, N = 4+2*WIDTH (4096 vectors at WIDTH=4), cleared on IDLE->RUN.
REQ-022 SHALL drive from the counter combinationally in RUN: alu_op=cnt[N-1:N-3], alu_in_c=cnt[2*WIDTH], alu_in_x=cnt[2*WIDTH-1:WIDTH], alu_in_y=cnt[WIDTH-1:0].
REQ-023 SHALL drive all alu_* outputs to 0 in IDLE.
REQ-024 SHALL apply one vector per cycle; the response to a vector is sampled at the edge ending the cycle in which it is driven.
REQ-025 SHALL compress each response r = zero-extended {alu_zero, alu_overflow, alu_out_c, alu_out_s} as misr <= {misr[SIG_W-2:0],0} ^ (misr[SIG_W-1] ? POLY : 0) ^ r.
REQ-026 SHALL load misr with SEED on IDLE->RUN.
REQ-027 SHALL increment the counter after each sample and, when the sampled count is all-ones, go to IDLE instead of wrapping.
REQ-028 SHALL, on that final edge, assert done for exactly one cycle, clear busy, and register pass = (misr_next == expected_sig).
REQ-029 SHALL keep busy=1 for exactly 2^N cycles, from the edge after start is sampled.
REQ-030 SHALL ignore start while busy=1; start held high in the done cycle SHALL NOT begin a new run before the next edge in IDLE.
REQ-031 SHALL clear pass on IDLE->RUN.
REQ-032 SHALL keep signature equal to the MISR register at all times; it is frozen in IDLE.

Reset
REQ-033 SHALL, on rst_n=0 at any time including mid-run, asynchronously enter IDLE with counter=0, misr=SEED, busy=0, done=0, pass=0, and all alu_* outputs 0.
REQ-034 SHALL NOT resume an aborted run after reset; a new start is required.

Structure
REQ-035 SHALL take POLY (16'h100B, x^16+x^12+x^3+x+1), the state enum, and the default SEED from shared package alu_bist_pkg.
REQ-036 SHALL place the MISR in sub-module alu_bist_misr (ports clk, rst_n, load, enable, data_in, sig_out).
REQ-037 SHALL NOT instantiate the alu itself; the integration top connects them.

Verification
REQ-038 SHALL cover: start pulse in IDLE -> busy=1 next cycle, first driven vector op=0, in_c=0, x=0, y=0.
REQ-039 SHALL cover: counter reaching 0x123 -> op=0, in_c=1, x=2, y=3 driven in that cycle.
REQ-040 SHALL cover: run against real alu with expected_sig from the bench model -> done pulse after 4096 busy cycles, pass=1; same run with expected_sig bit 0 flipped -> pass=0.
REQ-041 SHALL cover: stub ALU with out_s[0] stuck at 1 -> final signature differs from fault-free value, pass=0.
REQ-042 SHALL cover: start asserted again at vector 50 -> ignored, counter continues, run length unchanged.
REQ-043 SHALL cover: rst_n low at vector 100 -> busy=0, alu_* = 0, signature=16'hFFFF immediately; no done pulse follows.
